fetch_ifid: RTL and testbench



---
 rtl/fetch_ifid_if.sv | 28 ++
 rtl/fetch_ifid.sv | 261 ++++++++++++++++++++++++++
 tb/tb_fetch_ifid.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ifid_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ifid_if
// Purpose  : Instruction-memory request/response bus between the fetch
//            stage (master) and the multi-cycle instruction memory (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_ifid_if;
  logic        imem_req;    // request, held until imem_done
  logic [15:0] imem_addr;   // fetch address, stable while imem_req
  logic [15:0] imem_rdata;  // instruction, valid with imem_done
  logic        imem_done;   // access complete

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_done
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_done
  );
endinterface
`default_nettype wire

// File: rtl/fetch_ifid.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ifid
// Purpose  : Instruction-fetch stage plus IF/ID pipeline register for the
//            16-bit five-stage pipeline. Owns the PC, drives the multi-cycle
//            instruction memory and presents instruction / PC+2 to decode.
//            Optional feature macro: FETCH_HALT_DETECT_EN (stop fetching
//            once an opcode 5'b00000 instruction reaches IF/ID).
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ifid #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         PCwriteEn,
  input  logic         IFIDwriteEn,
  input  logic         redirect,
  input  logic [15:0]  redirect_pc,
  fetch_ifid_if.master imem,
  output logic [15:0]  ifid_instr,
  output logic [15:0]  ifid_pc2,
  output logic         ifid_valid,
  output logic         fetch_busy
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_stFetch = 2'd0;  // request outstanding to memory
  localparam logic [1:0] c_stHold  = 2'd1;  // fetched word parked, decode stalled
  localparam logic [1:0] c_stHalt  = 2'd2;  // halt opcode seen, fetch stopped

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [1:0]  r_state;
  logic [15:0] r_pc;
  logic [15:0] r_bufInstr;
  logic [15:0] r_bufPc2;
  logic        r_pend;
  logic [15:0] r_pendPc;
  logic        r_reqActive;  // current request has already been up >= 1 cycle
  logic [15:0] r_ifidInstr;
  logic [15:0] r_ifidPc2;
  logic        r_ifidValid;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic [1:0]  w_stateNext;
  logic [15:0] w_pcNext;
  logic [15:0] w_bufInstrNext;
  logic [15:0] w_bufPc2Next;
  logic        w_pendNext;
  logic [15:0] w_pendPcNext;
  logic        w_reqActiveNext;
  logic [15:0] w_ifidInstrNext;
  logic [15:0] w_ifidPc2Next;
  logic        w_ifidValidNext;

  logic        w_req;        // request line as seen by memory
  logic        w_done;       // a response we actually accept
  logic        w_adv;        // both hazard enables high: pipeline may advance
  logic        w_redirNow;   // redirect effective at a completing access
  logic [15:0] w_pcPlus2;
  logic        w_haltRdata;  // word arriving from memory is a halt
  logic        w_haltBuf;    // parked word is a halt

  assign w_adv     = PCwriteEn & IFIDwriteEn;
  assign w_pcPlus2 = r_pc + 16'd2;
  assign w_req     = (r_state == c_stFetch) & ~rst;

  // A response is only taken once the request has been visible for a full
  // cycle; this drops a stray completion left over from an access that a
  // reset cut short, and the first cycle of every new address.
  assign w_done     = w_req & imem.imem_done & r_reqActive;
  assign w_redirNow = redirect | r_pend;

`ifdef FETCH_HALT_DETECT_EN
  assign w_haltRdata = (imem.imem_rdata[15:11] == 5'b00000);
  assign w_haltBuf   = (r_bufInstr[15:11] == 5'b00000);
`else
  assign w_haltRdata = 1'b0;
  assign w_haltBuf   = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_stFetch;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      c_stFetch: begin
        if (w_done && !w_redirNow) begin
          if (!w_adv) begin
            w_stateNext = c_stHold;
          end else if (w_haltRdata) begin
            w_stateNext = c_stHalt;
          end
        end
      end
      c_stHold: begin
        if (redirect) begin
          w_stateNext = c_stFetch;
        end else if (w_adv) begin
          w_stateNext = w_haltBuf ? c_stHalt : c_stFetch;
        end
      end
      c_stHalt: begin
        if (redirect) begin
          w_stateNext = c_stFetch;
        end
      end
      default: w_stateNext = c_stFetch;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath next values: PC, hold buffer, deferred redirect and IF/ID
  // --------------------------------------------------------------------------
  always_comb begin
    w_pcNext        = r_pc;
    w_bufInstrNext  = r_bufInstr;
    w_bufPc2Next    = r_bufPc2;
    w_pendNext      = r_pend;
    w_pendPcNext    = r_pendPc;
    w_ifidInstrNext = r_ifidInstr;
    w_ifidPc2Next   = r_ifidPc2;
    w_ifidValidNext = r_ifidValid;
    // Same address stays on the bus next cycle unless this cycle completes it.
    w_reqActiveNext = w_req & ~w_done;

    case (r_state)
      c_stFetch: begin
        if (!w_done) begin
          // Memory is still busy: remember the latest redirect, it is applied
          // when the in-flight access finishes.
          if (redirect) begin
            w_pendNext   = 1'b1;
            w_pendPcNext = redirect_pc;
          end
          if (IFIDwriteEn) begin
            w_ifidInstrNext = NOP_INSTR;
            w_ifidPc2Next   = 16'h0000;
            w_ifidValidNext = 1'b0;
          end
        end else if (w_redirNow) begin
          // Fetched word belongs to the wrong path: drop it and refetch.
          w_pcNext   = redirect ? redirect_pc : r_pendPc;
          w_pendNext = 1'b0;
          if (IFIDwriteEn) begin
            w_ifidInstrNext = NOP_INSTR;
            w_ifidPc2Next   = 16'h0000;
            w_ifidValidNext = 1'b0;
          end
        end else if (w_adv) begin
          w_ifidInstrNext = imem.imem_rdata;
          w_ifidPc2Next   = w_pcPlus2;
          w_ifidValidNext = 1'b1;
          w_pcNext        = w_pcPlus2;
        end else begin
          // Decode is stalled: park the word instead of refetching it later.
          w_bufInstrNext = imem.imem_rdata;
          w_bufPc2Next   = w_pcPlus2;
          if (IFIDwriteEn) begin
            w_ifidInstrNext = NOP_INSTR;
            w_ifidPc2Next   = 16'h0000;
            w_ifidValidNext = 1'b0;
          end
        end
      end
      c_stHold: begin
        if (redirect) begin
          w_pcNext = redirect_pc;
        end else if (w_adv) begin
          w_ifidInstrNext = r_bufInstr;
          w_ifidPc2Next   = r_bufPc2;
          w_ifidValidNext = 1'b1;
          w_pcNext        = w_pcPlus2;
        end else if (IFIDwriteEn) begin
          w_ifidInstrNext = NOP_INSTR;
          w_ifidPc2Next   = 16'h0000;
          w_ifidValidNext = 1'b0;
        end
      end
      c_stHalt: begin
        if (redirect) begin
          w_pcNext = redirect_pc;
        end else if (IFIDwriteEn) begin
          w_ifidInstrNext = NOP_INSTR;
          w_ifidPc2Next   = 16'h0000;
          w_ifidValidNext = 1'b0;
        end
      end
      default: begin
        w_pcNext = r_pc;
      end
    endcase

    // A flush always wins over a decode stall.
    if (redirect) begin
      w_ifidInstrNext = NOP_INSTR;
      w_ifidPc2Next   = 16'h0000;
      w_ifidValidNext = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_bufInstr  <= NOP_INSTR;
      r_bufPc2    <= 16'h0000;
      r_pend      <= 1'b0;
      r_pendPc    <= 16'h0000;
      r_reqActive <= 1'b0;
      r_ifidInstr <= NOP_INSTR;
      r_ifidPc2   <= 16'h0000;
      r_ifidValid <= 1'b0;
    end else begin
      r_pc        <= w_pcNext;
      r_bufInstr  <= w_bufInstrNext;
      r_bufPc2    <= w_bufPc2Next;
      r_pend      <= w_pendNext;
      r_pendPc    <= w_pendPcNext;
      r_reqActive <= w_reqActiveNext;
      r_ifidInstr <= w_ifidInstrNext;
      r_ifidPc2   <= w_ifidPc2Next;
      r_ifidValid <= w_ifidValidNext;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    imem.imem_req  = w_req;
    imem.imem_addr = r_pc;
    fetch_busy     = w_req & ~imem.imem_done;
    ifid_instr     = r_ifidInstr;
    ifid_pc2       = r_ifidPc2;
    ifid_valid     = r_ifidValid;
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ifid.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ifid
// Purpose  : Self-checking bench for fetch_ifid. A memory responder with
//            random latency feeds the DUT; a program-order model predicts
//            which instructions must reach IF/ID and queues them; a monitor
//            pops and compares every new IF/ID load.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_ifid;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PCwriteEn = 1'b1;
  logic        IFIDwriteEn = 1'b1;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc2;
  logic        ifid_valid;
  logic        fetch_busy;

  fetch_ifid_if fif ();

  fetch_ifid dut (
    .clk         (clk),
    .rst         (rst),
    .PCwriteEn   (PCwriteEn),
    .IFIDwriteEn (IFIDwriteEn),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (fif),
    .ifid_instr  (ifid_instr),
    .ifid_pc2    (ifid_pc2),
    .ifid_valid  (ifid_valid),
    .fetch_busy  (fetch_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // scoreboard and program-order model
  exp_t        sbq[$];
  logic [15:0] mpc = 16'h0000;  // address of the next instruction in program order
  bit          held = 1'b0;     // an accepted word is parked in the DUT
  bit          dirty = 1'b0;    // in-flight access was overtaken by a redirect
  bit          haltOn = 1'b0;

  // memory responder
  bit prevSreq = 1'b0;
  bit prevDone = 1'b0;
  int prevAge = 0;
  int lat = 1;
  int latMin = 1;
  int latMax = 1;
  bit stallOnDone = 1'b0;
  bit redirAtAge1 = 1'b0;
  logic [15:0] redirAtAge1Pc = 16'h0000;
  bit pushedNow = 1'b0;

  // handed from driver to monitor
  bit curRedirect = 1'b0;
  bit curStall = 1'b0;
  bit curLoadNext = 1'b0;

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] memf(input logic [15:0] a);
    logic [15:0] h;
    if (haltOn && a == 16'h0030) return 16'h0000;
    if (a == 16'h0000) return 16'hC005;
    if (a == 16'h0002) return 16'hC006;
    if (a == 16'h0010) return 16'h4A21;
    h = a * 16'h9E37 + 16'h1234;
    return {1'b1, h[14:0]};
  endfunction

  // One clock cycle: respond from memory, apply hazard/redirect inputs and
  // advance the program-order model.
  task automatic step(input bit rd, input logic [15:0] rpc, input bit st);
    bit sreq, doneNow, acc, loadNext, rdE, stE;
    logic [15:0] saddr, rpcE;
    int curAge;
    @(posedge clk);
    #1;
    sreq  = fif.imem_req;
    saddr = fif.imem_addr;
    if (!sreq) curAge = 0;
    else if (prevSreq && !prevDone) curAge = prevAge + 1;
    else curAge = 0;
    if (sreq && curAge == 0) lat = $urandom_range(latMax, latMin);
    doneNow = sreq && (curAge >= lat);
    rdE  = rd;
    rpcE = rpc;
    if (redirAtAge1 && sreq && curAge == 1) begin
      rdE = 1'b1;
      rpcE = redirAtAge1Pc;
      redirAtAge1 = 1'b0;
    end
    acc = doneNow && !dirty && !rdE;
    stE = st | (stallOnDone && acc);
    loadNext = 1'b0;
    pushedNow = 1'b0;
    if (held) begin
      chk1("hold_req", sreq, 1'b0);
      if (rdE) begin
        void'(sbq.pop_back());
        held = 1'b0;
      end else if (!stE) begin
        held = 1'b0;
        loadNext = 1'b1;
      end
    end else if (acc) begin
      chk16("fetch_addr", saddr, mpc);
      sbq.push_back('{instr: memf(mpc), pc2: mpc + 16'd2});
      mpc = mpc + 16'd2;
      pushedNow = 1'b1;
      if (stE) held = 1'b1;
      else loadNext = 1'b1;
    end
    if (doneNow) dirty = 1'b0;
    else if (rdE && sreq) dirty = 1'b1;
    if (rdE) mpc = rpcE;
    prevSreq = sreq;
    prevDone = doneNow;
    prevAge  = curAge;
    fif.imem_done  = doneNow;
    fif.imem_rdata = doneNow ? memf(saddr) : 16'($urandom);
    redirect    = rdE;
    redirect_pc = rpcE;
    PCwriteEn   = !stE;
    IFIDwriteEn = !stE;
    curRedirect = rdE;
    curStall    = stE;
    curLoadNext = loadNext;
  endtask

  // Reset sequence; optionally injects a stray completion in the first cycle
  // after release, which the DUT must ignore.
  task automatic doReset(input bit stray);
    rst = 1'b1;
    fif.imem_done = 1'b0;
    redirect = 1'b0;
    PCwriteEn = 1'b1;
    IFIDwriteEn = 1'b1;
    curRedirect = 1'b0;
    curStall = 1'b0;
    curLoadNext = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk1("rst_req", fif.imem_req, 1'b0);
      chk1("rst_busy", fetch_busy, 1'b0);
    end
    chk16("rst_instr", ifid_instr, 16'h0800);
    chk16("rst_pc2", ifid_pc2, 16'h0000);
    chk1("rst_valid", ifid_valid, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sbq.delete();
    mpc = 16'h0000;
    held = 1'b0;
    dirty = 1'b0;
    #1;
    chk1("first_req", fif.imem_req, 1'b1);
    chk16("first_addr", fif.imem_addr, 16'h0000);
    fif.imem_done  = stray;
    fif.imem_rdata = 16'hDEAD;
    prevSreq = 1'b1;
    prevDone = 1'b0;
    prevAge  = 0;
    lat = $urandom_range(latMax, latMin);
  endtask

  // Monitor: every new IF/ID load is popped from the scoreboard; flushes and
  // load timing are checked cycle by cycle.
  initial begin : monitor
    bit pV, pS, pR, pL, newLoad;
    exp_t e;
    pV = 0; pS = 0; pR = 0; pL = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pV = 0; pS = 0; pR = 0; pL = 0;
      end else begin
        newLoad = ifid_valid && !(pV && pS);
        if (pR) begin
          chk1("flush_valid", ifid_valid, 1'b0);
          chk16("flush_instr", ifid_instr, 16'h0800);
          chk16("flush_pc2", ifid_pc2, 16'h0000);
        end
        chk1("load_timing", newLoad, pL);
        if (newLoad) begin
          if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_underflow: got load %h want none", ifid_instr);
          end else begin
            e = sbq.pop_front();
            chk16("ifid_instr", ifid_instr, e.instr);
            chk16("ifid_pc2", ifid_pc2, e.pc2);
          end
        end
        chk1("busy", fetch_busy, fif.imem_req && !fif.imem_done);
        pV = ifid_valid;
        pS = curStall;
        pR = curRedirect;
        pL = curLoadNext;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin : driver
    bit found, rd, st;
    logic [15:0] rp;
    fif.imem_done = 1'b0;
    fif.imem_rdata = 16'h0000;

    // back-to-back fetch with single-cycle memory
    latMin = 1; latMax = 1;
    doReset(1'b0);
    repeat (6) step(1'b0, 16'h0000, 1'b0);

    // stall exactly when the word at 0x0010 returns, hold 3 cycles
    step(1'b1, 16'h0010, 1'b0);
    stallOnDone = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b0, 16'h0000, 1'b0);
      found = pushedNow;
    end
    stallOnDone = 1'b0;
    chk1("hold_seen", found, 1'b1);
    step(1'b0, 16'h0000, 1'b1);
    step(1'b0, 16'h0000, 1'b1);
    repeat (4) step(1'b0, 16'h0000, 1'b0);

    // 3-cycle memory, redirect during the wait
    latMin = 3; latMax = 3;
    redirAtAge1 = 1'b1;
    redirAtAge1Pc = 16'h0100;
    repeat (14) step(1'b0, 16'h0000, 1'b0);

    // flush while decode stalled
    latMin = 1; latMax = 2;
    step(1'b1, 16'h0200, 1'b1);
    repeat (4) step(1'b0, 16'h0000, 1'b0);

    // PC wrap
    latMin = 1; latMax = 1;
    step(1'b1, 16'hFFFE, 1'b0);
    repeat (6) step(1'b0, 16'h0000, 1'b0);

    // halt opcode at 0x0030
    haltOn = 1'b1;
    step(1'b1, 16'h0030, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b0, 16'h0000, 1'b0);
      found = pushedNow;
    end
    chk1("halt_fetch_seen", found, 1'b1);
`ifdef FETCH_HALT_DETECT_EN
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 16'h0000, 1'b0);
      chk1("halt_req", fif.imem_req, 1'b0);
    end
    step(1'b1, 16'h0040, 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    chk1("halt_exit_req", fif.imem_req, 1'b1);
    chk16("halt_exit_addr", fif.imem_addr, 16'h0040);
`else
    step(1'b0, 16'h0000, 1'b0);
    chk1("nohalt_req", fif.imem_req, 1'b1);
    chk16("nohalt_addr", fif.imem_addr, 16'h0032);
`endif
    haltOn = 1'b0;
    repeat (4) step(1'b0, 16'h0000, 1'b0);

    // randomized traffic with mid-stream resets
    latMin = 1; latMax = 4;
    for (int i = 0; i < 1500; i++) begin
      if (i == 500 || i == 1000) begin
        doReset(1'($urandom_range(1, 0)));
      end else begin
        rd = ($urandom_range(11, 0) == 0);
        st = ($urandom_range(3, 0) == 0);
        rp = ($urandom_range(7, 0) == 0) ? 16'hFFFE : (16'($urandom) & 16'hFFFE);
        step(rd, rp, st);
      end
    end

    // drain: no further completions, everything queued must have arrived
    latMin = 40; latMax = 40;
    repeat (4) step(1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL sb_empty: got %0d pending want 0", sbq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
